// File: rtl/mbist_pattern_encoder.sv
// mbist_pattern_encoder
//   Read-side MBIST checker. It encodes memory read data back to a 3-bit
//   background index and compares it with the expected index. It counts
//   mismatches in a saturating counter, keeps a sticky fail flag, and gives a
//   pass/fail verdict at the end of each session (IDLE -> RUN -> DRAIN -> DONE).
//
//   Optional feature macro: MBIST_FAIL_LOG_EN
//     When defined, the address and data of the first mismatching beat are
//     logged. When undefined, fail_addr and fail_data are tied to 0.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   start, end_in  session start (also restarts a session) / last beat marker
//   rd_valid       rd_data, rd_addr and exp_q are valid this cycle
//   rd_data        8-bit read data
//   rd_addr        read address
//   exp_q          expected index
//   q_out          encoded index of the last accepted beat (7 = invalid)
//   q_valid        1-cycle pulse: q_out and mismatch updated
//   mismatch       last accepted beat failed
//   err_cnt        saturating mismatch count for this session
//   fail_flag      sticky: any mismatch this session
//   busy           session in RUN or DRAIN
//   result_valid   verdict available (DONE)
//   pass           in DONE: no mismatches
//   fail_addr      address of the first mismatch
//   fail_data      data of the first mismatch
module mbist_pattern_encoder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              end_in,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        exp_q,
  output logic [2:0]        q_out,
  output logic              q_valid,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              fail_flag,
  output logic              busy,
  output logic              result_valid,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        fail_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       q_out_q, q_out_d;
  logic             q_valid_q, q_valid_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_flag_q, fail_flag_d;

  logic [2:0] enc;
  logic       beat_bad;
  logic       accept;
  logic       clr;
  logic       first_fail;

  always_comb begin
    enc = 3'b111;
    case (rd_data)
      8'b1010_1010: enc = 3'b000;
      8'b0101_0101: enc = 3'b001;
      8'b1111_0000: enc = 3'b010;
      8'b0000_1111: enc = 3'b011;
      8'b0000_0000: enc = 3'b100;
      8'b1111_1111: enc = 3'b101;
      default:      enc = 3'b111;
    endcase
  end

  // Expected indices 110 and 111 are illegal, so they always fail.
  assign beat_bad = (enc != exp_q) || (exp_q[2:1] == 2'b11);

  // A start in RUN restarts the session and takes priority over the beat.
  assign accept     = (state_q == RUN) && rd_valid && !start;
  assign first_fail = accept && beat_bad && !fail_flag_q;

  always_comb begin
    state_d     = state_q;
    q_out_d     = q_out_q;
    q_valid_d   = 1'b0;
    mismatch_d  = mismatch_q;
    err_cnt_d   = err_cnt_q;
    fail_flag_d = fail_flag_q;
    clr         = 1'b0;

    case (state_q)
      IDLE:  if (start) begin state_d = RUN; clr = 1'b1; end
      RUN: begin
        if (start)       begin state_d = RUN; clr = 1'b1; end
        else if (end_in) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  if (start) begin state_d = RUN; clr = 1'b1; end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      err_cnt_d   = '0;
      fail_flag_d = 1'b0;
    end else if (accept) begin
      q_out_d    = enc;
      q_valid_d  = 1'b1;
      mismatch_d = beat_bad;
      if (beat_bad) begin
        fail_flag_d = 1'b1;
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_out_q     <= '0;
      q_valid_q   <= 1'b0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
      fail_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_out_q     <= q_out_d;
      q_valid_q   <= q_valid_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
      fail_flag_q <= fail_flag_d;
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [7:0]        fail_data_q, fail_data_d;

  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (clr) begin
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if (first_fail) begin
      fail_addr_d = rd_addr;
      fail_data_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
`else
  // No logging: the address and the first-fail qualifier have no sink.
  logic unused_log;
  assign unused_log = ^{rd_addr, first_fail};
  assign fail_addr  = '0;
  assign fail_data  = '0;
`endif

  assign q_out        = q_out_q;
  assign q_valid      = q_valid_q;
  assign mismatch     = mismatch_q;
  assign err_cnt      = err_cnt_q;
  assign fail_flag    = fail_flag_q;
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign result_valid = (state_q == DONE);
  assign pass         = (state_q == DONE) && (err_cnt_q == '0);

endmodule

// File: tb/tb_mbist_pattern_encoder.sv
module tb_mbist_pattern_encoder;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, end_in = 1'b0, rd_valid = 1'b0;
  logic [7:0]        rd_data = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [2:0]        exp_q = '0;
  logic [2:0]        q_out;
  logic              q_valid, mismatch, fail_flag, busy, result_valid, pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [7:0]        fail_data;

  mbist_pattern_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .end_in(end_in), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_addr(rd_addr), .exp_q(exp_q), .q_out(q_out),
    .q_valid(q_valid), .mismatch(mismatch), .err_cnt(err_cnt),
    .fail_flag(fail_flag), .busy(busy), .result_valid(result_valid),
    .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] q;
    logic       m;
    logic [7:0] cnt;
    logic       f;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [7:0] pats [0:5] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF};
  bit         m_run  = 0;
  int         m_cnt  = 0;
  bit         m_flag = 0;
  int         m_faddr = 0, m_fdata = 0;

  function automatic int ref_enc(logic [7:0] d);
    for (int i = 0; i < 6; i++) if (d == pats[i]) return i;
    return 7;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per q_valid pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_valid) begin
      if (sb.size() == 0) check("unexpected_q_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("q_out", q_out, e.q);
        check("mismatch", mismatch, e.m);
        check("err_cnt_beat", err_cnt, e.cnt);
        check("fail_flag_beat", fail_flag, e.f);
      end
    end
  end

  task automatic beat(int d, int a, int e, bit last);
    int  enc;
    bit  bad;
    rd_valid = 1; rd_data = d[7:0]; rd_addr = a[ADDR_W-1:0];
    exp_q = e[2:0]; end_in = last;
    if (m_run) begin
      enc = ref_enc(d[7:0]);
      bad = (enc != e) || (e >= 6);
      if (bad) begin
        if (!m_flag) begin m_faddr = a; m_fdata = d; end
        m_flag = 1;
        m_cnt  = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
      sb.push_back('{q: enc[2:0], m: bad, cnt: m_cnt[7:0], f: m_flag});
      if (last) m_run = 0;
    end
    @(negedge clk);
    rd_valid = 0; end_in = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
    m_run = 1; m_cnt = 0; m_flag = 0; m_faddr = 0; m_fdata = 0;
    check("busy_after_start", busy, 1);
    check("err_cnt_after_start", err_cnt, 0);
    check("fail_flag_after_start", fail_flag, 0);
  endtask

  // Called at the negedge following the end_in beat (DRAIN).
  task automatic finish_session(bit drain_start);
    check("busy_drain", busy, 1);
    check("result_valid_drain", result_valid, 0);
    start = drain_start;
    @(negedge clk);
    start = 0;
    check("result_valid_done", result_valid, 1);
    check("busy_done", busy, 0);
    check("pass", pass, m_cnt == 0);
    check("err_cnt_done", err_cnt, m_cnt);
    check("fail_flag_done", fail_flag, m_flag);
`ifdef MBIST_FAIL_LOG_EN
    check("fail_addr", fail_addr, m_faddr);
    check("fail_data", fail_data, m_fdata);
`else
    check("fail_addr", fail_addr, 0);
    check("fail_data", fail_data, 0);
`endif
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_q_out"}, q_out, 0);
    check({tag, "_q_valid"}, q_valid, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_fail_flag"}, fail_flag, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_fail_data"}, fail_data, 0);
  endtask

  initial begin
    int n, d, e;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    // rd_valid in IDLE is ignored
    beat(8'hAA, 1, 0, 0);
    check("idle_no_q_valid", q_valid, 0);

    // All legal patterns match
    do_start();
    for (int i = 0; i < 6; i++) beat(pats[i], i, i, i == 5);
    finish_session(0);

    // Invalid data against expected 010; start from DONE is honored
    do_start();
    beat(8'hF1, 8'h3C, 2, 0);
    beat(8'hAA, 8'h10, 0, 1);
    finish_session(0);

    // Illegal expected indices; start in DRAIN is ignored
    do_start();
    beat(8'hAA, 1, 6, 0);
    beat(8'hAA, 2, 7, 1);
    finish_session(1);

    // Saturation
    do_start();
    for (int i = 0; i < CMAX + 5; i++) beat(8'h55, i, 0, i == CMAX + 4);
    finish_session(0);

    // Restart mid-RUN after 4 mismatches
    do_start();
    for (int i = 0; i < 4; i++) beat(8'h12, i, 3, 0);
    check("cnt_before_restart", err_cnt, 4);
    do_start();
    beat(8'h0F, 9, 3, 1);
    finish_session(0);

    // Randomized sessions
    for (int s = 0; s < 20; s++) begin
      do_start();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        e = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        case ($urandom_range(0, 3))
          0:       d = $urandom_range(0, 255);
          1:       d = pats[$urandom_range(0, 5)];
          default: d = pats[e % 6];
        endcase
        beat(d, $urandom_range(0, 255), e, i == n - 1);
      end
      finish_session($urandom_range(0, 1));
    end

    // Reset mid-session with a beat in flight
    do_start();
    beat(8'h77, 5, 1, 0);
    rst = 1; rd_valid = 1; rd_data = 8'hAA; exp_q = 3'd0;
    @(negedge clk);
    rst = 0; rd_valid = 0;
    m_run = 0;
    check_all_zero("midrst");
    repeat (3) @(negedge clk);
    check("midrst_still_idle", busy, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mbist_pattern_encoder.md
# mbist_pattern_encoder

Read-side companion to the MBIST background decoder: takes memory read data, encodes it back to the 3-bit background index, and compares that index against the expected one. It counts mismatches, keeps a sticky fail flag and issues a pass/fail verdict at the end of each test session. It sits between the memory read port and the MBIST controller, mirroring the write-side decoder.

## Interface
Parameters:
- ADDR_W, 8, width of the read address tagged onto each beat
- CNT_W, 8, width of the saturating mismatch counter

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begins a session, clearing counters and flags
- end_in  input  1  marks the last beat of a session
- rd_valid  input  1  rd_data/rd_addr/exp_q valid this cycle
- rd_data  input  8  data read from memory
- rd_addr  input  ADDR_W  address of rd_data
- exp_q  input  3  expected background index
- q_out  output  3  encoded index of last accepted beat
- q_valid  output  1  q_out/mismatch valid (1-cycle pulse)
- mismatch  output  1  last accepted beat failed
- err_cnt  output  CNT_W  mismatches this session, saturating
- fail_flag  output  1  sticky: any mismatch this session
- busy  output  1  high in RUN or DRAIN
- result_valid  output  1  high in DONE
- pass  output  1  in DONE: 1 iff err_cnt == 0
- fail_addr  output  ADDR_W  address of first mismatch
- fail_data  output  8  rd_data of first mismatch

## Operation
- Encoding: 8'b10101010→000, 01010101→001, 11110000→010, 00001111→011, 00000000→100, 11111111→101. Any other value→3'b111 (invalid code).
- Compare: mismatch = (encoded != exp_q) OR (exp_q is 110 or 111). Illegal expected indices always fail.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start→RUN.
  - RUN: beats with rd_valid are accepted. end_in→DRAIN. start→RUN with a full clear (restart).
  - DRAIN: exactly 1 cycle, then →DONE.
  - DONE: holds until start→RUN.
- On each transition into RUN: err_cnt, fail_flag, fail_addr and fail_data are cleared.
- rd_valid outside RUN is ignored: no q_valid, no counting.
- err_cnt increments once per mismatching beat and holds at 2^CNT_W−1.
- fail_flag sets on the first mismatch and clears only on start or rst.
- Reset: state IDLE; every output 0, including q_out=3'b000 and pass=0.

## Timing
- Latency 1: a beat accepted at edge N drives q_out, q_valid and mismatch after edge N+1. err_cnt and fail_flag reflect the beat after that same edge.
- A beat with rd_valid and end_in in the same RUN cycle is accepted and counted.
- busy rises the cycle after start is sampled. result_valid and pass are valid the cycle after DRAIN, at least 2 cycles after the end_in beat.
- start and end_in together in RUN: start wins and the session restarts.
- rst mid-session: immediate return to IDLE; the in-flight beat is discarded.
- start while in DRAIN is ignored. start while in DONE is honored.

## Configuration
- MBIST_FAIL_LOG_EN defined: fail_addr and fail_data capture rd_addr and rd_data of the first mismatching beat in a session and hold until the next start or rst.
- MBIST_FAIL_LOG_EN undefined: no capture registers are built; fail_addr and fail_data are tied to 0. All other behaviour is unchanged.

## Test plan
- Expected indices 000..101 each fed its matching pattern, then end_in → q_out follows 000..101, mismatch=0 on every beat, err_cnt=0, pass=1.
- exp_q=010 with rd_data=8'b11110001 at rd_addr=8'h3C → q_out=111, mismatch=1, err_cnt=1, fail_flag=1, fail_addr=8'h3C, fail_data=8'hF1 (logging enabled), pass=0 in DONE.
- exp_q=110 and exp_q=111 with rd_data=8'hAA → mismatch=1 on both beats, err_cnt=2.
- CNT_W=2 with 5 mismatching beats → err_cnt saturates at 3.
- rd_valid while in IDLE → no q_valid. start mid-RUN with err_cnt=4 → err_cnt=0 and fail_flag=0 the next cycle.
- rst asserted in RUN with a beat in flight → next cycle all outputs 0, busy=0, and no further q_valid appears.
